load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-port load/store unit between a core request channel
//                and a word-wide data memory. Handles byte/half/word loads
//                with sign/zero extension and sub-word stores through
//                read-modify-write. Misaligned accesses either error out or,
//                with MISALIGNED_SPLIT_EN defined, are split across two
//                consecutive words.
//  Ports       : clk, reset                  - clock, sync active-high reset
//                req_valid/req_ready         - request handshake
//                req_we, req_funct3          - store flag, access size/sign
//                req_addr, req_wdata         - byte address, store data
//                resp_valid/rdata/err        - one-cycle completion
//                mem_we/addr/wdata, mem_rdata- word memory port (comb read)
//  Config      : MISALIGNED_SPLIT_EN (optional split of misaligned accesses)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        req_valid,
    output logic             req_ready,
    input  wire logic        req_we,
    input  wire logic [2:0]  req_funct3,
    input  wire logic [31:0] req_addr,
    input  wire logic [31:0] req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  wire logic [31:0] mem_rdata
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD0  = 3'd1;
    localparam logic [2:0] c_RD1  = 3'd2;
    localparam logic [2:0] c_WR0  = 3'd3;
    localparam logic [2:0] c_WR1  = 3'd4;
    localparam logic [2:0] c_RESP = 3'd5;

`ifdef MISALIGNED_SPLIT_EN
    localparam logic c_SPLIT_EN = 1'b1;
`else
    localparam logic c_SPLIT_EN = 1'b0;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_split;
    logic [31:0] r_w0;
    logic [31:0] r_w1;

    // ---------------- request decode (IDLE only) ----------------
    logic w_illegal;
    logic w_misal;
    logic w_err;
    logic w_split;

    assign w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);
    assign w_misal   = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                       ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11));
    assign w_err     = w_illegal || (w_misal && !c_SPLIT_EN);
    assign w_split   = w_misal && c_SPLIT_EN;

    assign req_ready = (r_state == c_IDLE) && !reset;

    // ---------------- next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    if (w_err)
                        w_next = c_RESP;
                    else if (req_we && (req_funct3 == 3'b010) && !w_split)
                        w_next = c_WR0;   // aligned sw needs no read
                    else
                        w_next = c_RD0;
                end
            end
            c_RD0:   w_next = r_split ? c_RD1 : (r_we ? c_WR0 : c_RESP);
            c_RD1:   w_next = r_we ? c_WR0 : c_RESP;
            c_WR0:   w_next = r_split ? c_WR1 : c_RESP;
            c_WR1:   w_next = c_RESP;
            c_RESP:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_err    <= 1'b0;
            r_split  <= 1'b0;
            r_w0     <= 32'd0;
            r_w1     <= 32'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_IDLE) && req_valid) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_err;
                r_split  <= w_split;
            end
            if (r_state == c_RD0) r_w0 <= mem_rdata;
            if (r_state == c_RD1) r_w1 <= mem_rdata;
        end
    end

    // ---------------- store merge over the w1:w0 window ----------------
    logic [7:0]  w_lanes;
    logic [63:0] w_mask;
    logic [63:0] w_data64;
    logic [63:0] w_merged;

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_lanes = 8'h01 << r_addr[1:0];
            2'b01:   w_lanes = 8'h03 << r_addr[1:0];
            default: w_lanes = 8'h0F << r_addr[1:0];
        endcase
    end

    for (genvar i = 0; i < 8; i++) begin : g_mask
        assign w_mask[i*8 +: 8] = {8{w_lanes[i]}};
    end

    assign w_data64 = {32'd0, r_wdata} << {r_addr[1:0], 3'b000};
    assign w_merged = ({r_w1, r_w0} & ~w_mask) | (w_data64 & w_mask);

    // ---------------- load extraction ----------------
    logic [31:0] w_lo;
    logic [31:0] w_ext;

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_lo = r_w0;
            2'd1:    w_lo = {r_w1[7:0],  r_w0[31:8]};
            2'd2:    w_lo = {r_w1[15:0], r_w0[31:16]};
            default: w_lo = {r_w1[23:0], r_w0[31:24]};
        endcase
        case (r_funct3)
            3'b000:  w_ext = {{24{w_lo[7]}},  w_lo[7:0]};
            3'b001:  w_ext = {{16{w_lo[15]}}, w_lo[15:0]};
            3'b010:  w_ext = w_lo;
            3'b100:  w_ext = {24'd0, w_lo[7:0]};
            3'b101:  w_ext = {16'd0, w_lo[15:0]};
            default: w_ext = 32'd0;
        endcase
    end

    // ---------------- outputs (decoded from state; zero outside use) ----
    logic [31:0] w_base;
    assign w_base = {r_addr[31:2], 2'b00};

    always_comb begin
        mem_addr = 32'd0;
        case (r_state)
            c_RD0, c_WR0: mem_addr = w_base;
            c_RD1, c_WR1: mem_addr = w_base + 32'd4;
            default:      mem_addr = 32'd0;
        endcase
    end

    assign mem_we     = (r_state == c_WR0) || (r_state == c_WR1);
    assign mem_wdata  = (r_state == c_WR0) ? w_merged[31:0]  :
                        (r_state == c_WR1) ? w_merged[63:32] : 32'd0;
    assign resp_valid = (r_state == c_RESP);
    assign resp_err   = (r_state == c_RESP) && r_err;
    assign resp_rdata = ((r_state == c_RESP) && !r_err && !r_we) ? w_ext : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit with a
//                128-word behavioural memory (address bits [8:2]) and a
//                write log. Expectations follow MISALIGNED_SPLIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // behavioural memory + logs
    logic [31:0] mem [0:127];
    logic [31:0] wa  [0:63];
    logic [31:0] wd  [0:63];
    int          wr_cnt  = 0;
    int          acc_cnt = 0;

    assign mem_rdata = mem[mem_addr[8:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[8:2]] <= mem_wdata;
            wa[wr_cnt[5:0]]    <= mem_addr;
            wd[wr_cnt[5:0]]    <= mem_wdata;
            wr_cnt             <= wr_cnt + 1;
        end
        if (mem_we || (mem_addr != 32'd0)) acc_cnt <= acc_cnt + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wdat,
                         output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wdat;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; rd = 32'd0; er = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (resp_valid) begin
                lat = n; rd = resp_rdata; er = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          w_s;
    int          a_s;
    logic        seen;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  {31'd0, req_ready},  32'd0);
        check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        check("rst_we",     {31'd0, mem_we},     32'd0);
        check("rst_addr",   mem_addr,            32'd0);
        check("rst_wdata",  mem_wdata,           32'd0);
        reset = 1'b0;

        // loads from word 0x100
        mem[64] = 32'h8899AABB;
        w_s = wr_cnt;
        issue(1'b0, 3'b000, 32'h102, 32'd0, lat, rd, er);
        check("lb_lat", 32'(lat), 32'd2);
        check("lb_data", rd, 32'hFFFFFF99);
        check("lb_err", {31'd0, er}, 32'd0);
        issue(1'b0, 3'b100, 32'h102, 32'd0, lat, rd, er);
        check("lbu_data", rd, 32'h00000099);
        issue(1'b0, 3'b001, 32'h102, 32'd0, lat, rd, er);
        check("lh_data", rd, 32'hFFFF8899);
        issue(1'b0, 3'b101, 32'h100, 32'd0, lat, rd, er);
        check("lhu_data", rd, 32'h0000AABB);
        issue(1'b0, 3'b010, 32'h100, 32'd0, lat, rd, er);
        check("lw_data", rd, 32'h8899AABB);
        check("lw_lat", 32'(lat), 32'd2);
        check("loads_nowrite", 32'(wr_cnt - w_s), 32'd0);

        // sh read-modify-write
        w_s = wr_cnt;
        issue(1'b1, 3'b001, 32'h100, 32'h00001234, lat, rd, er);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_nwr", 32'(wr_cnt - w_s), 32'd1);
        check("sh_waddr", wa[w_s], 32'h100);
        check("sh_wdata", wd[w_s], 32'h88991234);
        check("sh_rdata0", rd, 32'd0);

        // sb into top lane
        issue(1'b1, 3'b000, 32'h103, 32'hFFFFFF55, lat, rd, er);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_mem", mem[64], 32'h55991234);

        // aligned sw
        w_s = wr_cnt;
        issue(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, lat, rd, er);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_waddr", wa[w_s], 32'h104);
        check("sw_mem", mem[65], 32'hCAFEF00D);

        // illegal requests
        a_s = acc_cnt;
        issue(1'b0, 3'b011, 32'h100, 32'd0, lat, rd, er);
        check("ill_lat", 32'(lat), 32'd1);
        check("ill_err", {31'd0, er}, 32'd1);
        check("ill_rdata", rd, 32'd0);
        issue(1'b1, 3'b100, 32'h100, 32'h12, lat, rd, er);
        check("ill_st_err", {31'd0, er}, 32'd1);
        check("ill_noacc", 32'(acc_cnt - a_s), 32'd0);

        // half at offset 1 is legal
        mem[64] = 32'h44332211;
        mem[65] = 32'h88776655;
        issue(1'b0, 3'b001, 32'h101, 32'd0, lat, rd, er);
        check("lh_off1", rd, 32'h00003322);
        check("lh_off1_err", {31'd0, er}, 32'd0);

        // misaligned lw at 0x103
        w_s = wr_cnt;
        issue(1'b0, 3'b010, 32'h103, 32'd0, lat, rd, er);
`ifdef MISALIGNED_SPLIT_EN
        check("mlw_lat", 32'(lat), 32'd3);
        check("mlw_data", rd, 32'h77665544);
        check("mlw_err", {31'd0, er}, 32'd0);
`else
        check("mlw_lat", 32'(lat), 32'd1);
        check("mlw_err", {31'd0, er}, 32'd1);
        check("mlw_data", rd, 32'd0);
`endif
        check("mlw_nowrite", 32'(wr_cnt - w_s), 32'd0);

        // misaligned sw wrapping the address space
        mem[127] = 32'h11112222;
        mem[0]   = 32'h33334444;
        w_s = wr_cnt;
        issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'hDEADBEEF, lat, rd, er);
`ifdef MISALIGNED_SPLIT_EN
        check("msw_lat", 32'(lat), 32'd5);
        check("msw_nwr", 32'(wr_cnt - w_s), 32'd2);
        check("msw_a0", wa[w_s], 32'hFFFFFFFC);
        check("msw_d0", wd[w_s], 32'hBEEF2222);
        check("msw_a1", wa[w_s + 1], 32'h00000000);
        check("msw_d1", wd[w_s + 1], 32'h3333DEAD);
`else
        check("msw_lat", 32'(lat), 32'd1);
        check("msw_err", {31'd0, er}, 32'd1);
        check("msw_nwr", 32'(wr_cnt - w_s), 32'd0);
`endif

        // reset in RD0 of an sb
        w_s = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h100; req_wdata = 32'hAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rr_ready_in_rst", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rr_ready_after", {31'd0, req_ready}, 32'd1);
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (resp_valid || mem_we) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("rr_no_activity", {31'd0, seen}, 32'd0);
        check("rr_nowrite", 32'(wr_cnt - w_s), 32'd0);
        check("rr_mem_kept", mem[64], 32'h44332211);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
